// File: rtl/rect_fill_engine.sv
// Turns aggregated payload packets into raster-ordered framebuffer pixel writes over a clipped rectangle.
// Optional RECT_FILL_SKID_EN adds a one-entry packet buffer for packets arriving while busy.
module rect_fill_engine #(
   parameter int MAX_PAYLD_PKT_BITS = 56,
   parameter int FB_W               = 160,
   parameter int FB_H               = 120,
   parameter int SYM_SIZE           = 8
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_pkt_valid,
   input  logic [MAX_PAYLD_PKT_BITS-1:0] i_pkt_data,
   input  logic                          i_sym_mode,
   input  logic                          i_wr_ready,
   output logic                          o_wr_valid,
   output logic [7:0]                    o_wr_x,
   output logic [7:0]                    o_wr_y,
   output logic [15:0]                   o_wr_color,
   output logic                          o_busy,
   output logic                          o_done,
   output logic                          o_pkt_drop
);

   typedef enum logic [2:0] {S_IDLE, S_LATCH, S_SETUP, S_FILL, S_DONE} state_t;

   localparam logic [8:0] FB_W9 = 9'(FB_W);
   localparam logic [8:0] FB_H9 = 9'(FB_H);
   localparam logic [7:0] SYM8  = 8'(SYM_SIZE);

   state_t                        state_q, state_d;
   logic [MAX_PAYLD_PKT_BITS-1:0] pkt_q, pkt_d;
   logic                          mode_q, mode_d;
   logic [7:0]                    x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
   logic [15:0]                   color_q, color_d;
   logic [8:0]                    x_end_q, x_end_d, y_end_q, y_end_d;
   logic [7:0]                    x_q, x_d, y_q, y_d;
   logic [8:0]                    x_sum, y_sum;
   logic                          rect_empty, row_end, last_px, xfer;
   logic                          unused_pkt_bits;
`ifdef RECT_FILL_SKID_EN
   logic                          skid_vld_q, skid_vld_d;
   logic [MAX_PAYLD_PKT_BITS-1:0] skid_pkt_q, skid_pkt_d;
   logic                          skid_mode_q, skid_mode_d;
`endif

   assign unused_pkt_bits = ^pkt_q[MAX_PAYLD_PKT_BITS-1:48];

   // Clipping is done one bit wider than the coordinates so x0+w never wraps at 255.
   assign x_sum      = {1'b0, x0_q} + {1'b0, w_q};
   assign y_sum      = {1'b0, y0_q} + {1'b0, h_q};
   assign rect_empty = (w_q == 8'd0) || (h_q == 8'd0) ||
                       ({1'b0, x0_q} >= FB_W9) || ({1'b0, y0_q} >= FB_H9);
   assign row_end    = (({1'b0, x_q} + 9'd1) == x_end_q);
   assign last_px    = row_end && (({1'b0, y_q} + 9'd1) == y_end_q);
   assign xfer       = (state_q == S_FILL) && i_wr_ready;

   always_comb begin
      state_d    = state_q;
      pkt_d      = pkt_q;
      mode_d     = mode_q;
      x0_d       = x0_q;
      y0_d       = y0_q;
      w_d        = w_q;
      h_d        = h_q;
      color_d    = color_q;
      x_end_d    = x_end_q;
      y_end_d    = y_end_q;
      x_d        = x_q;
      y_d        = y_q;
      o_pkt_drop = 1'b0;
`ifdef RECT_FILL_SKID_EN
      skid_vld_d  = skid_vld_q;
      skid_pkt_d  = skid_pkt_q;
      skid_mode_d = skid_mode_q;
`endif

      case (state_q)
         S_IDLE: begin
`ifdef RECT_FILL_SKID_EN
            // A packet buffered during DONE is launched from here; a new strobe refills the entry.
            if (skid_vld_q) begin
               pkt_d       = skid_pkt_q;
               mode_d      = skid_mode_q;
               state_d     = S_LATCH;
               skid_vld_d  = i_pkt_valid;
               skid_pkt_d  = i_pkt_data;
               skid_mode_d = i_sym_mode;
            end else
`endif
            if (i_pkt_valid) begin
               pkt_d   = i_pkt_data;
               mode_d  = i_sym_mode;
               state_d = S_LATCH;
            end
         end
         S_LATCH: begin
            x0_d = pkt_q[7:0];
            y0_d = pkt_q[15:8];
            if (mode_q) begin
               w_d     = SYM8;
               h_d     = SYM8;
               color_d = pkt_q[39:24];
            end else begin
               w_d     = pkt_q[23:16];
               h_d     = pkt_q[31:24];
               color_d = pkt_q[47:32];
            end
            state_d = S_SETUP;
         end
         S_SETUP: begin
            x_end_d = (x_sum > FB_W9) ? FB_W9 : x_sum;
            y_end_d = (y_sum > FB_H9) ? FB_H9 : y_sum;
            x_d     = x0_q;
            y_d     = y0_q;
            state_d = rect_empty ? S_DONE : S_FILL;
         end
         S_FILL: begin
            if (xfer) begin
               if (last_px) begin
                  state_d = S_DONE;
               end else if (row_end) begin
                  x_d = x0_q;
                  y_d = y_q + 8'd1;
               end else begin
                  x_d = x_q + 8'd1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
`ifdef RECT_FILL_SKID_EN
            if (skid_vld_q) begin
               pkt_d      = skid_pkt_q;
               mode_d     = skid_mode_q;
               state_d    = S_LATCH;
               skid_vld_d = 1'b0;
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase

      if (i_pkt_valid && (state_q != S_IDLE)) begin
`ifdef RECT_FILL_SKID_EN
         // In DONE the entry is being drained this cycle, so it can always take the strobe.
         if (!skid_vld_q || (state_q == S_DONE)) begin
            skid_vld_d  = 1'b1;
            skid_pkt_d  = i_pkt_data;
            skid_mode_d = i_sym_mode;
         end else begin
            o_pkt_drop = 1'b1;
         end
`else
         o_pkt_drop = 1'b1;
`endif
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         pkt_q   <= '0;
         mode_q  <= 1'b0;
         x0_q    <= '0;
         y0_q    <= '0;
         w_q     <= '0;
         h_q     <= '0;
         color_q <= '0;
         x_end_q <= '0;
         y_end_q <= '0;
         x_q     <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         pkt_q   <= pkt_d;
         mode_q  <= mode_d;
         x0_q    <= x0_d;
         y0_q    <= y0_d;
         w_q     <= w_d;
         h_q     <= h_d;
         color_q <= color_d;
         x_end_q <= x_end_d;
         y_end_q <= y_end_d;
         x_q     <= x_d;
         y_q     <= y_d;
      end
   end

`ifdef RECT_FILL_SKID_EN
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         skid_vld_q  <= 1'b0;
         skid_pkt_q  <= '0;
         skid_mode_q <= 1'b0;
      end else begin
         skid_vld_q  <= skid_vld_d;
         skid_pkt_q  <= skid_pkt_d;
         skid_mode_q <= skid_mode_d;
      end
   end
`endif

   // Handshake: a pixel transfers on any rising edge where o_wr_valid && i_wr_ready.
   assign o_wr_valid = (state_q == S_FILL);
   assign o_wr_x     = x_q;
   assign o_wr_y     = y_q;
   assign o_wr_color = color_q;
   assign o_busy     = (state_q != S_IDLE);
   assign o_done     = (state_q == S_DONE);

endmodule

// File: doc/rect_fill_engine.md
Name: rect_fill_engine

Overview:
- Consumes aggregated payload packets from the UART packet aggregator and turns each one into a stream of framebuffer pixel writes covering a clipped rectangle.
- Program-mode packets carry explicit width and height. Symbol-mode packets draw a fixed SYM_SIZE square.
- Sits between the packet aggregator and the framebuffer write port.
- Outputs use a valid/ready handshake so the framebuffer arbiter can stall the engine.

Parameters:
- MAX_PAYLD_PKT_BITS, 56, payload width; must match the aggregator.
- FB_W, 160, framebuffer width in pixels (1..255).
- FB_H, 120, framebuffer height in pixels (1..255).
- SYM_SIZE, 8, edge length of the symbol-mode square (1..255).

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_pkt_valid  in  1  one-cycle strobe: i_pkt_data is valid.
- i_pkt_data  in  MAX_PAYLD_PKT_BITS  packet payload.
- i_sym_mode  in  1  aggregator symbol-mode flag; sampled with i_pkt_valid.
- i_wr_ready  in  1  framebuffer accepts the current write.
- o_wr_valid  out  1  pixel write pending.
- o_wr_x  out  8  pixel column.
- o_wr_y  out  8  pixel row.
- o_wr_color  out  16  RGB565 colour.
- o_busy  out  1  engine not in IDLE.
- o_done  out  1  one-cycle pulse at the end of each rectangle.
- o_pkt_drop  out  1  one-cycle pulse: packet discarded.

Behaviour:
- Reset is asynchronous, active-high; one clock, i_clk.
- All outputs reset to 0; state resets to IDLE; internal registers reset to 0.
- Program-mode payload: [7:0] x0, [15:8] y0, [23:16] w, [31:24] h, [47:32] colour; [55:48] ignored.
- Symbol-mode payload: [7:0] x0, [15:8] y0, [23:16] symbol index (ignored), [39:24] colour; w = h = SYM_SIZE.
- States:
  - IDLE -> LATCH on i_pkt_valid.
  - LATCH -> SETUP.
  - SETUP -> FILL, or -> DONE if the clipped rectangle is empty.
  - FILL -> DONE after the last write handshake.
  - DONE -> IDLE.
- LATCH registers x0, y0, w, h, colour and mode.
- SETUP computes x_end = min(x0+w, FB_W) and y_end = min(y0+h, FB_H) in 9-bit arithmetic; no wrap at 255.
- Empty rectangle: w==0, h==0, x0>=FB_W or y0>=FB_H. It produces zero writes and still pulses o_done.
- Latency: packet strobe in cycle N; first o_wr_valid in cycle N+3.
- FILL scans in raster order, x fastest, starting at (x0,y0). After x_end-1, x returns to x0 and y increments. The last pixel is (x_end-1, y_end-1).
- Handshake:
  - A transfer occurs when o_wr_valid && i_wr_ready.
  - o_wr_x, o_wr_y and o_wr_color are held stable while valid && !ready.
  - o_wr_valid stays high back-to-back: one pixel per cycle when ready is held high.
- o_wr_valid drops in the cycle after the final transfer. DONE asserts o_done for exactly one cycle.
- o_busy is 1 in LATCH, SETUP, FILL and DONE, and 0 only in IDLE.
- A packet arriving while o_busy=1 (including in DONE) is discarded, with o_pkt_drop pulsed the same cycle; see the optional feature.
- Reset mid-FILL aborts immediately. No o_done is generated and o_wr_valid goes to 0 asynchronously.
- i_wr_ready is ignored outside FILL.

Optional Feature:
- Macro: RECT_FILL_SKID_EN.
- Defined: adds a one-entry packet buffer (data plus mode bit).
  - A packet arriving while busy is stored if the buffer is empty; o_pkt_drop pulses only if the buffer is already full.
  - On DONE -> IDLE with the buffer full, the engine goes straight to LATCH from the buffer the next cycle and the buffer empties.
  - A packet strobe in that same cycle is stored into the freed entry.
- Undefined: no buffer; every packet received while busy is dropped.

Test Plan:
- Program packet x0=10, y0=20, w=3, h=2, colour=16'hF800, i_wr_ready=1 -> six writes (10,20),(11,20),(12,20),(10,21),(11,21),(12,21), first at strobe+3, colour F800. o_done pulses one cycle after (12,21).
- Same packet with i_wr_ready toggling 1,0,0,1,... -> identical 6-write sequence; outputs stable during stalls; no duplicates or skips.
- Clipping with x0=158, y0=118, w=5, h=5, FB 160x120 -> exactly four writes (158,118),(159,118),(158,119),(159,119). Also x0=200, w=10 -> zero writes, o_done still pulses.
- Symbol mode with i_sym_mode=1, x0=0, y0=0, colour bits [39:24]=16'h07E0 -> 64 writes covering 8x8, all 07E0.
- Second packet during FILL -> macro undefined: o_pkt_drop=1 for one cycle, only the first rectangle drawn. Macro defined: second rectangle starts one cycle after the first o_done; a third packet during FILL is dropped.
- Assert i_rst during FILL after 3 writes -> o_wr_valid=0 and o_busy=0 immediately, no o_done. A new packet after release draws normally.
